// File: rtl/bidir_port_ctrl.sv
// Registered bidirectional pad port: output register + registered enable drive the pad bus,
// incoming pad data passes through a synchroniser, and a small FSM inserts high-Z guard
// cycles on every change of bus direction.
module bidir_port_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] io,
  input  logic [WIDTH-1:0] dout,
  input  logic             drive_req,
  output logic             drive_ack,
  output logic [WIDTH-1:0] din,
  output logic             din_valid
);

  // Guard counter start value; unused when TURN_CYCLES is 0.
  localparam logic [3:0] TurnInit = (TURN_CYCLES > 0) ? 4'(TURN_CYCLES - 1) : 4'd0;
  localparam logic [2:0] FillFull = 3'(SYNC_STAGES);

  typedef enum logic [1:0] {StRx, StGapTx, StTx, StGapRx} state_e;

  state_e                             state_q, state_d;
  logic [3:0]                         cnt_q, cnt_d;
  logic [2:0]                         fill_q, fill_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]  sync_q, sync_d;
  logic [WIDTH-1:0]                   din_q, din_d;
  logic                               din_valid_q, din_valid_d;
  logic [WIDTH-1:0]                   out_q, out_d;
  logic                               oe_q, oe_d;
  logic                               ack_q, ack_d;

  // Next-state, guard counting, synchroniser shifting and output-register loading.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    sync_d  = sync_q;
    din_d   = din_q;
    out_d   = out_q;

    unique case (state_q)
      StRx: begin
        if (drive_req) begin
          // Leaving receive: synchroniser contents become stale, din keeps its last value.
          fill_d = 3'd0;
          if (TURN_CYCLES > 0) begin
            state_d = StGapTx;
            cnt_d   = TurnInit;
          end else begin
            state_d = StTx;
          end
        end else begin
          sync_d[0] = io;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
          end
          // din tracks the freshly loaded last stage so it is valid when din_valid rises.
          din_d = sync_d[SYNC_STAGES-1];
          if (fill_q != FillFull) begin
            fill_d = fill_q + 3'd1;
          end
        end
      end
      StGapTx: begin
        if (!drive_req) begin
          state_d = StRx;
        end else if (cnt_q == 4'd0) begin
          state_d = StTx;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StTx: begin
        if (!drive_req) begin
          if (TURN_CYCLES > 0) begin
            state_d = StGapRx;
            cnt_d   = TurnInit;
          end else begin
            state_d = StRx;
          end
        end
      end
      StGapRx: begin
        // Flush whatever was seen while the bus was turning around.
        sync_d = '0;
        if (cnt_q == 4'd0) begin
          state_d = StRx;
          fill_d  = 3'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StRx;
    endcase

    if ((state_d == StTx) || (state_q == StTx)) begin
      out_d = dout;
    end
    oe_d        = (state_d == StTx);
    ack_d       = (state_d == StTx);
    din_valid_d = (state_q == StRx) && (state_d == StRx) && (fill_d == FillFull);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRx;
      cnt_q       <= 4'd0;
      fill_q      <= 3'd0;
      sync_q      <= '0;
      din_q       <= '0;
      din_valid_q <= 1'b0;
      out_q       <= '0;
      oe_q        <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      sync_q      <= sync_d;
      din_q       <= din_d;
      din_valid_q <= din_valid_d;
      out_q       <= out_d;
      oe_q        <= oe_d;
      ack_q       <= ack_d;
    end
  end

  assign io        = oe_q ? out_q : {WIDTH{1'bz}};
  assign drive_ack = ack_q;
  assign din       = din_q;
  assign din_valid = din_valid_q;

endmodule
